// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Round-robin arbiter sharing one read port of a memory between
//             two requesters (0 = CPU fetch/load, 1 = loader/debug). One
//             access at a time; waits MEM_LAT edges for read data, then
//             returns it with a one-cycle ack pulse on the owning port.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 1      // edges from mem_addr update to valid mem_data, 1..15
) (
    input  logic              clk,
    input  logic              rst,
    // requester 0
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              ack0,
    output logic [DATA_W-1:0] data0,
    // requester 1
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ack1,
    output logic [DATA_W-1:0] data1,
    // memory side
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    // status
    output logic              busy,
    output logic              grant
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // Wait counter preload: the edge that loads the counter already counts as
    // the first latency edge, so only MEM_LAT-1 further edges are waited out.
    localparam logic [3:0] c_cnt_init = 4'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] data0_q, data0_d;
    logic [DATA_W-1:0] data1_q, data1_d;
    logic              ack0_q,  ack0_d;
    logic              ack1_q,  ack1_d;
    logic              busy_q,  busy_d;
    logic              grant_q, grant_d;
    logic              last_q,  last_d;
    logic [3:0]        cnt_q,   cnt_d;

    logic              w_elig0;
    logic              w_elig1;
    logic              w_sel;

    // A requester being acked this cycle is masked so its just-served request
    // is not granted a second time before it can drop req.
    assign w_elig0 = req0 & ~ack0_q;
    assign w_elig1 = req1 & ~ack1_q;

    // Tie goes to the requester that did not own the previous access.
    assign w_sel = (w_elig0 & w_elig1) ? ~last_q : w_elig1;

    // State and datapath registers; last resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data0_q <= '0;
            data1_q <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: grant in IDLE, count down latency in WAIT, then capture and ack.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data0_d = data0_q;
        data1_d = data1_q;
        ack0_d  = 1'b0;            // acks are single-cycle pulses
        ack1_d  = 1'b0;
        busy_d  = busy_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (w_elig0 | w_elig1) begin
                    // Address is sampled only here; later changes are ignored.
                    addr_d  = w_sel ? addr1 : addr0;
                    grant_d = w_sel;
                    last_d  = w_sel;
                    cnt_d   = c_cnt_init;
                    busy_d  = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Access completes even if the owner dropped its request.
                    if (grant_q) begin
                        data1_d = mem_data;
                        ack1_d  = 1'b1;
                    end else begin
                        data0_d = mem_data;
                        ack0_d  = 1'b1;
                    end
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign mem_addr = addr_q;
    assign data0    = data0_q;
    assign data1    = data1_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign busy     = busy_q;
    assign grant    = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter. Three instances with
//             MEM_LAT = 1, 3 and 2 share one clock; each sees a small
//             combinational memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Memory contents used by the tests; other addresses read as ~addr.
    function automatic logic [7:0] memf(input logic [7:0] a);
        case (a)
            8'h05:   memf = 8'hA7;
            8'h10:   memf = 8'h11;
            8'h20:   memf = 8'h22;
            8'h30:   memf = 8'h5C;
            8'h31:   memf = 8'h99;
            default: memf = ~a;
        endcase
    endfunction

    // ---------------- instance A: MEM_LAT = 1 ----------------
    logic       a_rst, a_req0, a_req1, a_ack0, a_ack1, a_busy, a_grant;
    logic [7:0] a_addr0, a_addr1, a_data0, a_data1, a_maddr, a_mdata;
    assign a_mdata = memf(a_maddr);

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst(a_rst),
        .req0(a_req0), .addr0(a_addr0), .ack0(a_ack0), .data0(a_data0),
        .req1(a_req1), .addr1(a_addr1), .ack1(a_ack1), .data1(a_data1),
        .mem_addr(a_maddr), .mem_data(a_mdata), .busy(a_busy), .grant(a_grant)
    );

    // ---------------- instance B: MEM_LAT = 3 ----------------
    logic       b_rst, b_req0, b_req1, b_ack0, b_ack1, b_busy, b_grant;
    logic [7:0] b_addr0, b_addr1, b_data0, b_data1, b_maddr, b_mdata;
    assign b_mdata = memf(b_maddr);

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(3)) u_lat3 (
        .clk(clk), .rst(b_rst),
        .req0(b_req0), .addr0(b_addr0), .ack0(b_ack0), .data0(b_data0),
        .req1(b_req1), .addr1(b_addr1), .ack1(b_ack1), .data1(b_data1),
        .mem_addr(b_maddr), .mem_data(b_mdata), .busy(b_busy), .grant(b_grant)
    );

    // ---------------- instance C: MEM_LAT = 2 ----------------
    logic       c_rst, c_req0, c_req1, c_ack0, c_ack1, c_busy, c_grant;
    logic [7:0] c_addr0, c_addr1, c_data0, c_data1, c_maddr, c_mdata;
    assign c_mdata = memf(c_maddr);

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(2)) u_lat2 (
        .clk(clk), .rst(c_rst),
        .req0(c_req0), .addr0(c_addr0), .ack0(c_ack0), .data0(c_data0),
        .req1(c_req1), .addr1(c_addr1), .ack1(c_ack1), .data1(c_data1),
        .mem_addr(c_maddr), .mem_data(c_mdata), .busy(c_busy), .grant(c_grant)
    );

    // One table row: inputs applied before an edge, outputs expected after it.
    typedef struct {
        logic       rst;
        logic       req0;
        logic [7:0] addr0;
        logic       req1;
        logic [7:0] addr1;
        logic       ack0;
        logic [7:0] data0;
        logic       ack1;
        logic [7:0] data1;
        logic [7:0] maddr;
        logic       busy;
        logic       grant;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic r0, input logic [7:0] a0,
                                input logic r1, input logic [7:0] a1,
                                input logic ea0, input logic [7:0] ed0,
                                input logic ea1, input logic [7:0] ed1,
                                input logic [7:0] ema, input logic eb, input logic eg);
        vec_t v;
        v.rst = rst; v.req0 = r0; v.addr0 = a0; v.req1 = r1; v.addr1 = a1;
        v.ack0 = ea0; v.data0 = ed0; v.ack1 = ea1; v.data1 = ed1;
        v.maddr = ema; v.busy = eb; v.grant = eg;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    initial begin
        a_rst = 1'b1; a_req0 = 1'b0; a_req1 = 1'b0; a_addr0 = '0; a_addr1 = '0;
        b_rst = 1'b1; b_req0 = 1'b0; b_req1 = 1'b0; b_addr0 = '0; b_addr1 = '0;
        c_rst = 1'b1; c_req0 = 1'b0; c_req1 = 1'b0; c_addr0 = '0; c_addr1 = '0;

        //            rst r0 a0    r1 a1    | ack0 d0    ack1 d1    maddr busy grant
        // reset and idle
        tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0));
        // single read, latency 1
        tbl.push_back(mk(0, 1, 8'h05, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h05, 1, 0));
        tbl.push_back(mk(0, 1, 8'h05, 0, 8'h00, 1, 8'hA7, 0, 8'h00, 8'h05, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 8'hA7, 0, 8'h00, 8'h05, 0, 0));
        // req0 held alone: masked during its ack cycle, ack every 3 cycles
        tbl.push_back(mk(0, 1, 8'h10, 0, 8'h00, 0, 8'hA7, 0, 8'h00, 8'h10, 1, 0));
        tbl.push_back(mk(0, 1, 8'h10, 0, 8'h00, 1, 8'h11, 0, 8'h00, 8'h10, 0, 0));
        tbl.push_back(mk(0, 1, 8'h10, 0, 8'h00, 0, 8'h11, 0, 8'h00, 8'h10, 0, 0));
        tbl.push_back(mk(0, 1, 8'h10, 0, 8'h00, 0, 8'h11, 0, 8'h00, 8'h10, 1, 0));
        tbl.push_back(mk(0, 1, 8'h10, 0, 8'h00, 1, 8'h11, 0, 8'h00, 8'h10, 0, 0));
        tbl.push_back(mk(0, 0, 8'h10, 0, 8'h00, 0, 8'h11, 0, 8'h00, 8'h10, 0, 0));
        // reset, then both held: first tie to 0, then alternation
        tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 8'h10, 1, 8'h20, 0, 8'h00, 0, 8'h00, 8'h10, 1, 0));
        tbl.push_back(mk(0, 1, 8'h10, 1, 8'h20, 1, 8'h11, 0, 8'h00, 8'h10, 0, 0));
        tbl.push_back(mk(0, 1, 8'h10, 1, 8'h20, 0, 8'h11, 0, 8'h00, 8'h20, 1, 1));
        tbl.push_back(mk(0, 1, 8'h10, 1, 8'h20, 0, 8'h11, 1, 8'h22, 8'h20, 0, 1));
        tbl.push_back(mk(0, 1, 8'h10, 1, 8'h20, 0, 8'h11, 0, 8'h22, 8'h10, 1, 0));
        tbl.push_back(mk(0, 1, 8'h10, 1, 8'h20, 1, 8'h11, 0, 8'h22, 8'h10, 0, 0));
        tbl.push_back(mk(0, 1, 8'h10, 1, 8'h20, 0, 8'h11, 0, 8'h22, 8'h20, 1, 1));
        // both requests dropped mid-access: ack1 still fires
        tbl.push_back(mk(0, 0, 8'h10, 0, 8'h20, 0, 8'h11, 1, 8'h22, 8'h20, 0, 1));
        tbl.push_back(mk(0, 0, 8'h10, 0, 8'h20, 0, 8'h11, 0, 8'h22, 8'h20, 0, 1));

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            a_rst   = tbl[i].rst;
            a_req0  = tbl[i].req0;
            a_addr0 = tbl[i].addr0;
            a_req1  = tbl[i].req1;
            a_addr1 = tbl[i].addr1;
            step();
            n_vec++;
            if (a_ack0 !== tbl[i].ack0 || a_data0 !== tbl[i].data0 ||
                a_ack1 !== tbl[i].ack1 || a_data1 !== tbl[i].data1 ||
                a_maddr !== tbl[i].maddr || a_busy !== tbl[i].busy ||
                a_grant !== tbl[i].grant) begin
                n_miss++;
                $display("FAIL vec%0d: got ack0=%b d0=%h ack1=%b d1=%h ma=%h busy=%b gnt=%b expected ack0=%b d0=%h ack1=%b d1=%h ma=%h busy=%b gnt=%b",
                         i, a_ack0, a_data0, a_ack1, a_data1, a_maddr, a_busy, a_grant,
                         tbl[i].ack0, tbl[i].data0, tbl[i].ack1, tbl[i].data1,
                         tbl[i].maddr, tbl[i].busy, tbl[i].grant);
            end
        end

        // ---- MEM_LAT=3: address change during WAIT is ignored ----
        b_rst = 1'b1; step(); b_rst = 1'b0; step();
        b_req1 = 1'b1; b_addr1 = 8'h30;
        step();                                    // grant edge E0
        chk("lat3_grant_maddr", b_maddr, 8'h30);
        chk("lat3_grant_busy",  b_busy,  1);
        chk("lat3_grant_gnt",   b_grant, 1);
        b_addr1 = 8'h31;
        for (int k = 1; k <= 2; k++) begin
            step();                                // E1, E2
            chk("lat3_wait_ack1",  b_ack1,  0);
            chk("lat3_wait_maddr", b_maddr, 8'h30);
            chk("lat3_wait_busy",  b_busy,  1);
        end
        step();                                    // E3
        chk("lat3_ack1",  b_ack1,  1);
        chk("lat3_data1", b_data1, 8'h5C);
        chk("lat3_busy0", b_busy,  0);
        b_req1 = 1'b0;
        step();
        chk("lat3_ack1_clr", b_ack1, 0);

        // ---- MEM_LAT=3: reset in the middle of a req0 access ----
        b_req0 = 1'b1; b_addr0 = 8'h05;
        step();
        chk("rstmid_grant_busy", b_busy, 1);
        b_rst = 1'b1;
        step();
        chk("rstmid_ack0",  b_ack0,  0);
        chk("rstmid_maddr", b_maddr, 8'h00);
        chk("rstmid_busy",  b_busy,  0);
        chk("rstmid_grant", b_grant, 0);
        chk("rstmid_data1", b_data1, 8'h00);
        b_rst = 1'b0; b_req0 = 1'b0; b_req1 = 1'b1; b_addr1 = 8'h20;
        step();
        chk("rstmid_req1_grant", b_grant, 1);
        chk("rstmid_req1_maddr", b_maddr, 8'h20);
        chk("rstmid_req1_busy",  b_busy,  1);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("rstmid_no_ack0", b_ack0, 0);
            chk("rstmid_ack1", b_ack1, (k == 3) ? 1 : 0);
        end
        chk("rstmid_data1_new", b_data1, 8'h22);
        chk("rstmid_data0_kept", b_data0, 8'h00);
        b_req1 = 1'b0;
        step();

        // ---- MEM_LAT=2: req1 alone, dropped in ack cycle, reasserted ----
        c_rst = 1'b1; step(); c_rst = 1'b0; step();
        for (int r = 0; r < 2; r++) begin
            logic [7:0] ad;
            ad = (r == 0) ? 8'h31 : 8'h30;
            c_req1 = 1'b1; c_addr1 = ad;
            step();                                // grant
            chk("lat2_grant", c_grant, 1);
            chk("lat2_maddr", c_maddr, ad);
            chk("lat2_busy",  c_busy,  1);
            step();                                // still waiting
            chk("lat2_wait_ack1", c_ack1, 0);
            step();                                // ack
            chk("lat2_ack1",  c_ack1,  1);
            chk("lat2_data1", c_data1, memf(ad));
            chk("lat2_data0", c_data0, 8'h00);
            c_req1 = 1'b0;
            step();
            chk("lat2_ack1_clr", c_ack1, 0);
            chk("lat2_idle_busy", c_busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Absolute time bound so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
